// File: rtl/johnson_monitor_if.sv
// Signal bundle between the Johnson counter side and johnson_monitor.
// master drives the sample and clear inputs; slave is the monitor itself.
interface johnson_monitor_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned CYC_W = 8,
  parameter int unsigned ERR_W = 4
);
  localparam int unsigned IW = $clog2(2 * N);

  logic             valid_in;
  logic [N-1:0]     code_in;
  logic             clr_cnt;
  logic [IW-1:0]    idx_out;
  logic             idx_valid;
  logic             legal;
  logic             locked;
  logic             seq_err;
  logic [CYC_W-1:0] wrap_cnt;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output valid_in, code_in, clr_cnt,
    input  idx_out, idx_valid, legal, locked, seq_err, wrap_cnt, err_cnt
  );

  modport slave (
    input  valid_in, code_in, clr_cnt,
    output idx_out, idx_valid, legal, locked, seq_err, wrap_cnt, err_cnt
  );
endinterface

// File: rtl/johnson_monitor.sv
// Health monitor for an N-bit Johnson counter: legality, decode, +1 step tracking, lock.
// Define JOHNSON_MON_WRAP_EN to build the wrap counter; otherwise wrap_cnt is tied to 0.
module johnson_monitor #(
  parameter int unsigned N        = 8,
  parameter int unsigned LOCK_LEN = 4,
  parameter int unsigned CYC_W    = 8,
  parameter int unsigned ERR_W    = 4
) (
  input logic              clk,
  input logic              rst_n,
  johnson_monitor_if.slave mon
);
  localparam int unsigned IW   = $clog2(2 * N);
  localparam int unsigned RING = 2 * N;
  localparam int unsigned RW   = 4;

  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    prev_q, prev_d;
  logic [RW-1:0]    run_q, run_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             legal_q, legal_d;
  logic             locked_q, locked_d;
  logic             seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic             code_legal;
  logic [IW-1:0]    code_idx;
  logic [IW-1:0]    prev_inc;
  logic [RW-1:0]    run_inc;
  logic             is_step, is_hold;
  int unsigned      trans, pop;

  // Legal iff at most one adjacent bit pair differs; index from popcount and MSB.
  always_comb begin
    trans = 0;
    pop   = 0;
    for (int unsigned i = 0; i < N - 1; i++) begin
      if (mon.code_in[i] != mon.code_in[i+1]) trans++;
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (mon.code_in[i]) pop++;
    end
    code_legal = (trans <= 1);
    code_idx   = mon.code_in[N-1] ? IW'(RING - pop) : IW'(pop);
  end

  always_comb begin
    prev_inc = (prev_q == IW'(RING - 1)) ? '0 : prev_q + IW'(1);
    run_inc  = run_q + RW'(1);
    is_step  = (code_idx == prev_inc);
    is_hold  = (code_idx == prev_q);
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    run_d       = run_q;
    idx_d       = idx_q;
    legal_d     = legal_q;
    idx_valid_d = 1'b0;
    seq_err_d   = 1'b0;
    if (mon.valid_in) begin
      idx_valid_d = 1'b1;
      legal_d     = code_legal;
      if (code_legal) idx_d = code_idx;
      unique case (state_q)
        UNLOCKED: begin
          if (code_legal) begin
            state_d = LOCKING;
            prev_d  = code_idx;
            run_d   = '0;
          end
        end
        LOCKING: begin
          if (!code_legal) begin
            state_d = UNLOCKED;
          end else if (is_step) begin
            run_d  = run_inc;
            prev_d = code_idx;
            if (run_inc == RW'(LOCK_LEN)) state_d = LOCKED;
          end else if (!is_hold) begin
            run_d  = '0;
            prev_d = code_idx;
          end
        end
        LOCKED: begin
          if (!code_legal) begin
            seq_err_d = 1'b1;
            state_d   = UNLOCKED;
          end else if (is_step) begin
            prev_d = code_idx;
          end else if (!is_hold) begin
            seq_err_d = 1'b1;
            state_d   = LOCKING;
            prev_d    = code_idx;
            run_d     = '0;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
    locked_d = (state_d == LOCKED);
    if (mon.clr_cnt)                 err_d = '0;
    else if (seq_err_d && err_q != '1) err_d = err_q + ERR_W'(1);
    else                              err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      prev_q      <= '0;
      run_q       <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      legal_q     <= 1'b0;
      locked_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      legal_q     <= legal_d;
      locked_q    <= locked_d;
      seq_err_q   <= seq_err_d;
      err_q       <= err_d;
    end
  end

`ifdef JOHNSON_MON_WRAP_EN
  logic [CYC_W-1:0] wrap_q, wrap_d;
  logic             wrap_hit;

  // A ring completes on a locked, legal last->0 step.
  always_comb begin
    wrap_hit = mon.valid_in && (state_q == LOCKED) && code_legal &&
               (prev_q == IW'(RING - 1)) && (code_idx == '0);
    if (mon.clr_cnt)   wrap_d = '0;
    else if (wrap_hit) wrap_d = wrap_q + CYC_W'(1);
    else               wrap_d = wrap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap_q <= '0;
    else        wrap_q <= wrap_d;
  end

  assign mon.wrap_cnt = wrap_q;
`else
  assign mon.wrap_cnt = '0;
`endif

  assign mon.idx_out   = idx_q;
  assign mon.idx_valid = idx_valid_q;
  assign mon.legal     = legal_q;
  assign mon.locked    = locked_q;
  assign mon.seq_err   = seq_err_q;
  assign mon.err_cnt   = err_q;
endmodule

// File: tb/tb_johnson_monitor.sv
// Bench for johnson_monitor (N=8, LOCK_LEN=4) against a table-driven reference model.
module tb_johnson_monitor;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  johnson_monitor_if #(.N(8), .CYC_W(8), .ERR_W(4)) bus ();

  johnson_monitor #(.N(8), .LOCK_LEN(4), .CYC_W(8), .ERR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  ring_code [16];
  int          m_state;  // 0 unlocked, 1 locking, 2 locked
  int          m_prev, m_run, m_idx, m_wrap, m_err;
  logic        m_iv, m_legal, m_locked, m_seq;
  logic [19:0] exp_vec;
  logic [19:0] dut_vec;

  assign dut_vec = {bus.idx_out, bus.idx_valid, bus.legal, bus.locked, bus.seq_err,
                    bus.wrap_cnt, bus.err_cnt};

  function automatic void pack_model();
    exp_vec = {4'(m_idx), m_iv, m_legal, m_locked, m_seq, 8'(m_wrap), 4'(m_err)};
  endfunction

  function automatic void model_reset();
    m_state = 0; m_prev = 0; m_run = 0; m_idx = 0; m_wrap = 0; m_err = 0;
    m_iv = 0; m_legal = 0; m_locked = 0; m_seq = 0;
    pack_model();
  endfunction

  function automatic void model_update(input logic v, input logic [7:0] c, input logic clr);
    int  idx;
    bit  found;
    bit  wrap_inc;
    idx = 0; found = 0; wrap_inc = 0;
    m_iv  = 0;
    m_seq = 0;
    if (v) begin
      for (int k = 0; k < 16; k++) if (ring_code[k] == c) begin found = 1; idx = k; end
      m_iv    = 1;
      m_legal = found;
      if (found) m_idx = idx;
      if (m_state == 0) begin
        if (found) begin m_state = 1; m_prev = idx; m_run = 0; end
      end else if (m_state == 1) begin
        if (!found) m_state = 0;
        else if (idx == (m_prev + 1) % 16) begin
          m_run++; m_prev = idx;
          if (m_run == 4) m_state = 2;
        end else if (idx != m_prev) begin
          m_run = 0; m_prev = idx;
        end
      end else begin
        if (!found) begin m_seq = 1; m_state = 0; end
        else if (idx == (m_prev + 1) % 16) begin
          if (m_prev == 15) wrap_inc = 1;
          m_prev = idx;
        end else if (idx != m_prev) begin
          m_seq = 1; m_state = 1; m_prev = idx; m_run = 0;
        end
      end
    end
    m_locked = (m_state == 2);
    if (m_seq && m_err < 15) m_err++;
`ifdef JOHNSON_MON_WRAP_EN
    if (wrap_inc) m_wrap = (m_wrap + 1) % 256;
`endif
    if (clr) begin m_err = 0; m_wrap = 0; end
    pack_model();
  endfunction

  // Called at a negedge; returns at the following negedge with outputs settled.
  task automatic drive(input logic v, input logic [7:0] c, input logic clr);
    bus.valid_in = v;
    bus.code_in  = c;
    bus.clr_cnt  = clr;
    @(posedge clk);
    model_update(v, c, clr);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.valid_in = 0; bus.code_in = '0; bus.clr_cnt = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) drive(1'b1, ring_code[k], 1'b0);
    bus.valid_in = 1; bus.code_in = ring_code[6];
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dut_vec !== 20'h0) begin
      bad++; $display("FAIL reset_async outputs=%h want=%h", dut_vec, 20'h0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'b0000_0001, 1'b0);
    total++;
    if ({bus.idx_out, bus.legal, bus.locked} !== {4'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_first_sample idx/legal/locked=%h want=%h",
                      {bus.idx_out, bus.legal, bus.locked}, {4'd1, 1'b1, 1'b0});
    end
    total++;
    if (dut_vec !== exp_vec) begin
      bad++; $display("FAIL reset_model got=%h want=%h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_clean_ring();
    int exp_w;
    for (int k = 0; k <= 16; k++) begin
      drive(1'b1, ring_code[k % 16], 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL ring_step%0d got=%h want=%h", k, dut_vec, exp_vec);
      end
      total++;
      if (bus.locked !== (k >= 4)) begin
        bad++; $display("FAIL ring_locked%0d got=%b want=%b", k, bus.locked, (k >= 4));
      end
    end
`ifdef JOHNSON_MON_WRAP_EN
    exp_w = 1;
`else
    exp_w = 0;
`endif
    total++;
    if (bus.wrap_cnt !== 8'(exp_w)) begin
      bad++; $display("FAIL ring_wrap got=%0d want=%0d", bus.wrap_cnt, exp_w);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 8'b0000_0101, 1'b0);
    total++;
    if ({bus.legal, bus.seq_err, bus.err_cnt, bus.locked, bus.idx_out} !==
        {1'b0, 1'b1, 4'd1, 1'b0, 4'd0}) begin
      bad++; $display("FAIL illegal_inject got=%h want=%h",
                      {bus.legal, bus.seq_err, bus.err_cnt, bus.locked, bus.idx_out},
                      {1'b0, 1'b1, 4'd1, 1'b0, 4'd0});
    end
    drive(1'b0, 8'h00, 1'b0);
    total++;
    if (bus.seq_err !== 1'b0 || bus.err_cnt !== 4'd1) begin
      bad++; $display("FAIL illegal_pulse seq_err=%b err=%0d want 0/1", bus.seq_err, bus.err_cnt);
    end
  endtask

  task automatic test_skip_hold();
    int seq [10] = '{13, 14, 15, 0, 1, 2, 3, 3, 5, 6};
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, ring_code[seq[k]], 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL skiphold_%0d got=%h want=%h", k, dut_vec, exp_vec);
      end
      if (k == 7) begin
        total++;
        if (bus.seq_err !== 1'b0 || bus.locked !== 1'b1) begin
          bad++; $display("FAIL hold_no_err seq_err=%b locked=%b want 0/1", bus.seq_err, bus.locked);
        end
      end
      if (k == 8) begin
        total++;
        if ({bus.seq_err, bus.locked, bus.err_cnt} !== {1'b1, 1'b0, 4'd2}) begin
          bad++; $display("FAIL skip_err got=%h want=%h",
                          {bus.seq_err, bus.locked, bus.err_cnt}, {1'b1, 1'b0, 4'd2});
        end
      end
    end
    for (int k = 7; k <= 9; k++) begin
      drive(1'b1, ring_code[k], 1'b0);
      total++;
      if (bus.locked !== (k == 9)) begin
        bad++; $display("FAIL relock_idx%0d locked=%b want=%b", k, bus.locked, (k == 9));
      end
    end
  endtask

  task automatic test_saturation_clear();
    for (int e = 0; e < 20; e++) begin
      for (int k = 0; k <= 4; k++) drive(1'b1, ring_code[k], 1'b0);
      drive(1'b1, 8'b0110_0110, 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL sat_err%0d got=%h want=%h", e, dut_vec, exp_vec);
      end
    end
    total++;
    if (bus.err_cnt !== 4'd15) begin
      bad++; $display("FAIL err_saturate got=%0d want=15", bus.err_cnt);
    end
    for (int k = 0; k <= 4; k++) drive(1'b1, ring_code[k], 1'b0);
    drive(1'b1, 8'b0000_0101, 1'b1);
    total++;
    if ({bus.seq_err, bus.err_cnt, bus.wrap_cnt} !== {1'b1, 4'd0, 8'd0}) begin
      bad++; $display("FAIL clr_wins got=%h want=%h",
                      {bus.seq_err, bus.err_cnt, bus.wrap_cnt}, {1'b1, 4'd0, 8'd0});
    end
  endtask

  task automatic test_stall();
    logic [19:0] held;
    for (int k = 0; k <= 4; k++) drive(1'b1, ring_code[k], 1'b0);
    drive(1'b1, ring_code[5], 1'b0);
    held = {dut_vec[19:16], 1'b0, dut_vec[14:13], 1'b0, dut_vec[11:0]};
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 8'($urandom), 1'b0);
      total++;
      if (dut_vec !== held || bus.locked !== 1'b1) begin
        bad++; $display("FAIL stall_%0d got=%h want=%h (locked=%b)", c, dut_vec, held, bus.locked);
      end
    end
    drive(1'b1, ring_code[6], 1'b0);
    total++;
    if (dut_vec !== exp_vec) begin
      bad++; $display("FAIL stall_resume got=%h want=%h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    int cur;
    int r;
    logic [7:0] c;
    logic v, clr;
    cur = 0;
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(99));
      v = 1'b1;
      if (r < 65)      cur = (cur + 1) % 16;
      else if (r < 75) cur = cur;
      else if (r < 83) cur = int'($urandom_range(15));
      if (r >= 83 && r < 91) c = 8'($urandom);
      else                   c = ring_code[cur];
      if (r >= 91) v = 1'b0;
      clr = ($urandom_range(99) < 3);
      drive(v, c, clr);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL random_%0d code=%h v=%b got=%h want=%h", n, c, v, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    logic [8:0] ones;
    total = 0;
    bad   = 0;
    for (int k = 0; k <= 8; k++) begin
      ones = (9'd1 << k) - 9'd1;
      ring_code[k] = ones[7:0];
    end
    for (int k = 9; k < 16; k++) ring_code[k] = 8'hFF << (k - 8);
    test_reset();
    test_clean_ring();
    test_illegal();
    test_skip_hold();
    test_saturation_clear();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
